// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W  = 16;
    localparam int unsigned FETCH_INSTR_W = 16;
    localparam int unsigned ENTRY_W       = FETCH_ADDR_W + FETCH_INSTR_W;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush and push+pop when full.
// The read port holds the last shown head while the FIFO is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata,
    output logic               empty,
    output logic               full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     last_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= fetch_entry_t'(wdata);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            // Track the visible head so outputs hold steady once drained or flushed.
            if (!empty) begin
                last_q <= mem_q[rd_ptr_q];
            end
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, RUN/HALT FSM and the fetch buffer.
// Optional FETCH_CTRL_PERF_EN adds a saturating stall_cnt output.
module fetch_ctrl
    import fetch_pkg::*;
#(
    // Buffered entry widths follow fetch_pkg; these must match it.
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic               do_pop;
    logic               do_push;
    fetch_entry_t       wr_entry;
    fetch_entry_t       rd_entry;
    logic [ENTRY_W-1:0] rd_bits;

    assign imem_addr      = fetch_pc_q;
    assign out_valid      = !fifo_empty;
    assign do_pop         = out_valid && out_ready;
    assign halted         = (state_q == HALT) && fifo_empty;
    assign wr_entry.pc    = fetch_pc_q;
    assign wr_entry.instr = imem_rdata;
    assign rd_entry       = fetch_entry_t'(rd_bits);
    assign out_pc         = rd_entry.pc;
    assign out_instr      = rd_entry.instr;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        do_push    = 1'b0;
        case (state_q)
            RUN:     if (halt_req)  state_d = HALT;
            HALT:    if (!halt_req) state_d = RUN;
            default: state_d = RUN;
        endcase
        // Redirect wins over fetching in either state.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (state_q == RUN && !halt_req && (!fifo_full || do_pop)) begin
            do_push    = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= {RESET_PC[ADDR_W-1:1], 1'b0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (rd_bits),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == RUN && !halt_req && !redirect_valid && !do_push &&
                     stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl plus hand sequences for throughput and stall count.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;

    logic [15:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic        out_valid, halted;
    logic [15:0] w_imem_addr, w_imem_rdata, w_out_instr, w_out_pc;
    logic        w_out_valid, w_halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] stall_cnt, w_stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = 16'h1000 + {1'b0, imem_addr[15:1]};
    assign w_imem_rdata = 16'h1000 + {1'b0, w_imem_addr[15:1]};

    fetch_ctrl #(
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    fetch_ctrl #(
        .DEPTH    (2),
        .RESET_PC (16'hFFFC)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (w_imem_addr),
        .imem_rdata     (w_imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (w_out_valid),
        .out_ready      (out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .halted         (w_halted)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cnt      (w_stall_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        halt;
        logic        chk;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eins;
        logic [15:0] eaddr;
        logic        eh;
        logic        chkw;
        logic [15:0] ewpc;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic rd, input logic rv, input logic [15:0] rpc,
                       input logic h, input logic c, input logic ev, input logic [15:0] epc,
                       input logic [15:0] eins, input logic [15:0] eaddr, input logic eh,
                       input logic cw, input logic [15:0] ewpc);
        vec_t t;
        t.rst = r;   t.rdy = rd;   t.rv = rv;     t.rpc = rpc;     t.halt = h;
        t.chk = c;   t.ev = ev;    t.epc = epc;   t.eins = eins;   t.eaddr = eaddr;
        t.eh = eh;   t.chkw = cw;  t.ewpc = ewpc;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt_req       = 1'b0;

        //   rst rdy rv rpc       h   chk v  pc        instr     addr      hl  cw wpc
        // Reset and streaming; dut_w wraps FFFC, FFFE, 0000, 0002.
        row(1, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0,  1, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0002, 0,  1, 16'hFFFC);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0002, 16'h1001, 16'h0004, 0,  1, 16'hFFFE);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0004, 16'h1002, 16'h0006, 0,  1, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0006, 16'h1003, 16'h0008, 0,  1, 16'h0002);
        // Backpressure: fills to 2, address holds at 0004, then drains in order.
        row(1, 1, 0, 16'h0000, 0,  0, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0002, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0004, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0004, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0004, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0004, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0004, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0002, 16'h1001, 16'h0006, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0004, 16'h1002, 16'h0008, 0,  0, 16'h0000);
        // Redirect to 0041 while full with a pop: one bubble, then 0040.
        row(0, 1, 1, 16'h0041, 0,  1, 1, 16'h0006, 16'h1003, 16'h000A, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h0006, 16'h1003, 16'h0040, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0040, 16'h1020, 16'h0042, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0042, 16'h1021, 16'h0044, 0,  0, 16'h0000);
        // Halt with two buffered: drains, halted, release resumes at 0048.
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0044, 16'h1022, 16'h0046, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 1,  1, 1, 16'h0044, 16'h1022, 16'h0048, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 1,  1, 1, 16'h0046, 16'h1023, 16'h0048, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 1,  1, 0, 16'h0046, 16'h1023, 16'h0048, 1,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h0046, 16'h1023, 16'h0048, 1,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h0046, 16'h1023, 16'h0048, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0048, 16'h1024, 16'h004A, 0,  0, 16'h0000);
        // Redirect while halted: PC moves, state stays halted.
        row(0, 1, 0, 16'h0000, 1,  1, 1, 16'h004A, 16'h1025, 16'h004C, 0,  0, 16'h0000);
        row(0, 1, 1, 16'h0101, 1,  1, 0, 16'h004A, 16'h1025, 16'h004C, 1,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 1,  1, 0, 16'h004A, 16'h1025, 16'h0100, 1,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h004A, 16'h1025, 16'h0100, 1,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 0, 16'h004A, 16'h1025, 16'h0100, 0,  0, 16'h0000);
        row(0, 1, 0, 16'h0000, 0,  1, 1, 16'h0100, 16'h1080, 16'h0102, 0,  0, 16'h0000);
        // Reset mid-operation with a full buffer discards everything.
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0102, 16'h1081, 16'h0104, 0,  0, 16'h0000);
        row(1, 0, 0, 16'h0000, 0,  1, 1, 16'h0102, 16'h1081, 16'h0106, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 16'h0000);
        row(0, 0, 0, 16'h0000, 0,  1, 1, 16'h0000, 16'h1000, 16'h0002, 0,  0, 16'h0000);

        next_cycle();
        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            halt_req       = vecs[i].halt;
            @(negedge clk);
            if (vecs[i].chk) begin
                check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].ev});
                check("out_pc",    i, {16'd0, out_pc},    {16'd0, vecs[i].epc});
                check("out_instr", i, {16'd0, out_instr}, {16'd0, vecs[i].eins});
                check("imem_addr", i, {16'd0, imem_addr}, {16'd0, vecs[i].eaddr});
                check("halted",    i, {31'd0, halted},    {31'd0, vecs[i].eh});
            end
            if (vecs[i].chkw) begin
                check("wrap_out_pc", i, {16'd0, w_out_pc}, {16'd0, vecs[i].ewpc});
            end
            next_cycle();
        end

        // Sustained throughput: one instruction per cycle with consecutive PCs.
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            logic [15:0] exp_pc;
            exp_pc = 16'(2 * k);
            @(negedge clk);
            check("tput_valid", 100 + k, {31'd0, out_valid}, 32'd1);
            check("tput_pc",    100 + k, {16'd0, out_pc}, {16'd0, exp_pc});
            check("tput_instr", 100 + k, {16'd0, out_instr},
                  {16'd0, 16'h1000 + {1'b0, exp_pc[15:1]}});
            check("tput_addr",  100 + k, {16'd0, imem_addr}, {16'd0, exp_pc + 16'd2});
            next_cycle();
        end

`ifdef FETCH_CTRL_PERF_EN
        // Ten cycles of backpressure from reset: two pushes, eight stalls.
        rst       = 1'b1;
        out_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        repeat (10) next_cycle();
        check("stall_cnt", 200, stall_cnt, 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
